// File: rtl/cla_serial_addsub.sv
// cla_serial_addsub: digit-serial adder/subtractor.
// One 4-bit carry-lookahead slice is evaluated per clock, LSB nibble first.
// The slice carry is kept in a flop between cycles, so the datapath is a
// single 4-bit CLA regardless of WIDTH. WIDTH must be a multiple of 4 and >= 8.

// 4-bit carry-lookahead slice: every carry is a flat generate/propagate term
// of c0, with no ripple through lower sum bits.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] sum_c,
  output logic       c3_c,
  output logic       c4_c
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  // Generate/propagate terms and flat lookahead carries
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c1   = g[0] | (p[0] & c0);
    c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3_c = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    c4_c = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    sum_c = p ^ {c3_c, c2, c1, c0};
  end

endmodule

module cla_serial_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] opa_q,    opa_d;
  logic [WIDTH-1:0] opb_q,    opb_d;
  logic             carry_q,  carry_d;
  logic [IW-1:0]    idx_q,    idx_d;
  logic [WIDTH-1:0] y_q,      y_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic [IW+1:0]    bit_base;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_sum;
  logic             nib_c3;
  logic             nib_c4;
  logic             last_slice;

  // Select the nibble pair addressed by the slice index
  always_comb begin
    bit_base   = {idx_q, 2'b00};
    nib_a      = opa_q[bit_base +: 4];
    nib_b      = opb_q[bit_base +: 4];
    last_slice = (idx_q == IW'(N - 1));
  end

  cla4_slice u_slice (
    .a     (nib_a),
    .b     (nib_b),
    .c0    (carry_q),
    .sum_c (nib_sum),
    .c3_c  (nib_c3),
    .c4_c  (nib_c4)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    y_d     = y_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtraction is a + ~b + ~borrow; inversion happens once at accept
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        y_d[bit_base +: 4] = nib_sum;
        carry_d            = nib_c4;
        idx_d              = idx_q + IW'(1);
        if (last_slice) begin
          // Slice carry-in to its MSB is the carry into bit WIDTH-1
          cout_d  = nib_c4;
          ovf_d   = nib_c3 ^ nib_c4;
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset wins over any request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/cla_serial_addsub.md
CLA_SERIAL_ADDSUB -- requirements
Module: cla_serial_addsub

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and >= 8.
REQ-002 Derived constant N = WIDTH/4, the number of 4-bit carry-lookahead slices processed.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request a new operation; sampled on the clk edge.
REQ-006 sub  input  1  mode: 0 = add (a+b+cin), 1 = subtract (a-b-cin).
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in in add mode, borrow-in in subtract mode.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  single-cycle completion pulse.
REQ-012 y  output  WIDTH  result.
REQ-013 cout  output  1  raw carry out of MSB slice (in sub mode, 1 = no borrow).
REQ-014 ovf  output  1  signed overflow flag.

Function
REQ-015 FSM states: IDLE, RUN, DONE.
REQ-016 IDLE or DONE with start=1: latch A=a, B=(sub ? ~b : b), carry=(sub ? ~cin : cin), clear nibble index i=0, go to RUN.
REQ-017 Latched operands SHALL be used for the whole operation; a/b/sub/cin changes after acceptance SHALL have no effect.
REQ-018 RUN: each cycle one 4-bit carry-lookahead slice SHALL compute A[4i+3:4i] + B[4i+3:4i] + carry using generate/propagate lookahead (no ripple within the slice), write the sum to y[4i+3:4i], store the slice carry-out to carry, increment i.
REQ-019 Nibbles SHALL be processed LSB first; after slice N-1 the state SHALL become DONE.
REQ-020 Latency: start accepted at edge k, busy=1 from edge k, done=1 during the cycle after edge k+N, busy=0 in that same cycle.
REQ-021 DONE lasts exactly one cycle; without start, next state IDLE; with start, a new operation is accepted (back-to-back allowed).
REQ-022 start while in RUN SHALL be ignored (no restart, no queuing).
REQ-023 cout SHALL equal the carry out of slice N-1.
REQ-024 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-025 y, cout, ovf SHALL update only at completion of the slice that produces them and SHALL hold their final values from DONE until the next accepted operation completes its first slice; intermediate y nibbles may be partial during RUN.
REQ-026 cout and ovf SHALL be valid only when done=1 or in IDLE after a completed operation.

Reset
REQ-027 rst=1 at an edge: state IDLE, busy=0, done=0, y=0, cout=0, ovf=0, i=0, internal carry=0.
REQ-028 rst SHALL take priority over start and SHALL abort an operation in RUN with no done pulse.
REQ-029 rst asserted and start=1 on the same edge: start ignored; first accept possible on the edge after rst deasserts.

Verification (WIDTH=16, N=4)
REQ-030 add 0x1234+0x4321, cin=0 -> done 4 cycles after accept edge, y=0x5555, cout=0, ovf=0.
REQ-031 add 0xFFFF+0x0001, cin=0 -> y=0x0000, cout=1, ovf=0; add 0x7FFF+0x0001 -> y=0x8000, cout=0, ovf=1.
REQ-032 sub 0x0005-0x0007, cin=0 -> y=0xFFFE, cout=0, ovf=0; sub 0x8000-0x0001 -> y=0x7FFF, cout=1, ovf=1.
REQ-033 add 0x00FF+0x0000, cin=1 -> y=0x0100 (carry propagates across slices); sub 0x0010-0x0000, cin=1 -> y=0x000F.
REQ-034 start pulsed again 2 cycles into RUN with different operands -> ignored, result of first operation unchanged; start held high in DONE cycle -> second operation accepted, its done 4 cycles later.
REQ-035 rst asserted 2 cycles into RUN -> next cycle busy=0, done=0, y=0; no done pulse; new start after rst completes normally.
